// File: rtl/branch_compare_seq.sv
// branch_compare_seq: multi-cycle MSB-first sliced comparator with RISC-V branch funct3 decode
module branch_compare_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8,
  parameter int EARLY_EXIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       i_funct3,
  input  logic             i_flush,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_lt,
  output logic             o_eq,
  output logic             o_taken,
  output logic             o_illegal
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int KW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
  localparam logic [WIDTH-1:0] MSB = {1'b1, {(WIDTH-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] ra, rb;
  logic [2:0] f3;
  logic [KW-1:0] k;
  logic found, first_lt;
  logic [CHUNK-1:0] sa, sb;
  logic diff, slt, fin_lt, fin_eq, fin_taken, fin_last;
  assign o_ready = state == IDLE;
  assign o_valid = state == DONE;
  assign sa = ra[k*CHUNK +: CHUNK];
  assign sb = rb[k*CHUNK +: CHUNK];
  // found/first_lt only ever get set in the constant-latency mode, so one finalise path serves both
  always_comb begin
    diff = sa != sb;
    slt = sa < sb;
    fin_lt = found ? first_lt : (diff && slt);
    fin_eq = !found && !diff;
    fin_taken = f3[2] ? (f3[0] ? !fin_lt : fin_lt) : (f3[1] ? 1'b0 : (f3[0] ? !fin_eq : fin_eq));
    fin_last = ((EARLY_EXIT != 0) && diff) || (k == '0);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ra <= '0;
      rb <= '0;
      f3 <= '0;
      k <= '0;
      found <= 1'b0;
      first_lt <= 1'b0;
      o_lt <= 1'b0;
      o_eq <= 1'b0;
      o_taken <= 1'b0;
      o_illegal <= 1'b0;
    end else if (i_flush) begin
      state <= IDLE;
      o_lt <= 1'b0;
      o_eq <= 1'b0;
      o_taken <= 1'b0;
      o_illegal <= 1'b0;
    end else begin
      case (state)
        IDLE: if (i_valid) begin
          // flipping the sign bits lets the unsigned slice scan produce signed order
          ra <= i_funct3[1] ? a : a ^ MSB;
          rb <= i_funct3[1] ? b : b ^ MSB;
          f3 <= i_funct3;
          k <= KW'(NCHUNK - 1);
          found <= 1'b0;
          first_lt <= 1'b0;
          state <= SCAN;
        end
        SCAN: begin
          if (diff && !found && (EARLY_EXIT == 0)) begin
            found <= 1'b1;
            first_lt <= slt;
          end
          if (fin_last) begin
            o_lt <= fin_lt;
            o_eq <= fin_eq;
            o_taken <= fin_taken;
            o_illegal <= !f3[2] && f3[1];
            state <= DONE;
          end else begin
            k <= k - 1'b1;
          end
        end
        DONE: if (i_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_branch_compare_seq.sv
// tb_branch_compare_seq: random and directed checks of both exit modes against a behavioural model
module tb_branch_compare_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic [2:0] f3 = '0;
  logic v1 = 1'b0, v0 = 1'b0, flush = 1'b0, rdy = 1'b0;
  logic r1, ov1, lt1, eq1, tk1, il1;
  logic r0, ov0, lt0, eq0, tk0, il0;
  bit sel = 1'b1;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  branch_compare_seq #(.WIDTH(32), .CHUNK(8), .EARLY_EXIT(1)) dut (
    .clk(clk), .rst_n(rst_n), .i_valid(v1), .o_ready(r1), .a(a), .b(b), .i_funct3(f3),
    .i_flush(flush), .o_valid(ov1), .i_ready(rdy), .o_lt(lt1), .o_eq(eq1), .o_taken(tk1), .o_illegal(il1));
  branch_compare_seq #(.WIDTH(32), .CHUNK(8), .EARLY_EXIT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .i_valid(v0), .o_ready(r0), .a(a), .b(b), .i_funct3(f3),
    .i_flush(flush), .o_valid(ov0), .i_ready(rdy), .o_lt(lt0), .o_eq(eq0), .o_taken(tk0), .o_illegal(il0));
  wire ord = sel ? r1 : r0;
  wire ovs = sel ? ov1 : ov0;
  wire lts = sel ? lt1 : lt0;
  wire eqs = sel ? eq1 : eq0;
  wire tks = sel ? tk1 : tk0;
  wire ils = sel ? il1 : il0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model(input bit ee, input logic [31:0] x, input logic [31:0] y, input logic [2:0] f,
                                output logic lt, output logic eq, output logic tk, output logic il, output int m);
    logic [31:0] d;
    d = x ^ y;
    il = f[2:1] == 2'b01;
    eq = x == y;
    lt = f[1] ? (x < y) : ($signed(x) < $signed(y));
    case (f)
      3'd0: tk = eq;
      3'd1: tk = !eq;
      3'd4, 3'd6: tk = lt;
      3'd5, 3'd7: tk = !lt;
      default: tk = 1'b0;
    endcase
    m = 4;
    if (ee) begin
      for (int i = 0; i < 4; i++) begin
        if (d[31-8*i -: 8] != 8'h0) begin
          m = i + 1;
          break;
        end
      end
    end
  endfunction

  task automatic check_quiet(input string tag);
    chk({tag, "_ready"}, ord, 1);
    chk({tag, "_valid"}, ovs, 0);
    chk({tag, "_lt"}, lts, 0);
    chk({tag, "_eq"}, eqs, 0);
    chk({tag, "_taken"}, tks, 0);
    chk({tag, "_illegal"}, ils, 0);
  endtask

  task automatic watch_no_valid(input string tag);
    logic seen;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
      seen = seen | ovs;
    end
    chk(tag, seen, 0);
  endtask

  task automatic txn(input bit ee, input logic [31:0] ta, input logic [31:0] tb2, input logic [2:0] tf, input int hold);
    logic elt, eeq, etk, eil;
    int m, n;
    sel = ee;
    model(ee, ta, tb2, tf, elt, eeq, etk, eil, m);
    chk("idle_ready", ord, 1);
    a = ta;
    b = tb2;
    f3 = tf;
    if (ee) v1 = 1'b1; else v0 = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (n == 1) begin
        v1 = 1'b0;
        v0 = 1'b0;
        a = $urandom;
        b = $urandom;
        f3 = 3'($urandom);
      end
    end while (!ovs && n < 20);
    chk("valid_timeout", ovs, 1);
    chk("latency", n - 1, m);
    chk("lt", lts, elt);
    chk("eq", eqs, eeq);
    chk("taken", tks, etk);
    chk("illegal", ils, eil);
    chk("done_ready", ord, 0);
    if (ee) v1 = 1'b1; else v0 = 1'b1;
    repeat (hold) begin
      a = $urandom;
      b = $urandom;
      f3 = 3'($urandom);
      @(posedge clk);
      #1;
      chk("bp_valid", ovs, 1);
      chk("bp_ready", ord, 0);
      chk("bp_lt", lts, elt);
      chk("bp_eq", eqs, eeq);
      chk("bp_taken", tks, etk);
      chk("bp_illegal", ils, eil);
    end
    rdy = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_valid", ovs, 0);
    chk("rel_ready", ord, 1);
    rdy = 1'b0;
    v1 = 1'b0;
    v0 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] x, y;
    #2;
    sel = 1'b1;
    check_quiet("rst1");
    sel = 1'b0;
    check_quiet("rst0");
    #10 rst_n = 1'b1;
    txn(1, 32'hFFFFFFFF, 32'h00000001, 3'b100, 0);
    txn(1, 32'hFFFFFFFF, 32'h00000001, 3'b110, 0);
    txn(1, 32'hFFFFFFFF, 32'h00000001, 3'b111, 0);
    txn(1, 32'h12345678, 32'h12345678, 3'b000, 0);
    txn(1, 32'h12345678, 32'h12345678, 3'b001, 0);
    txn(1, 32'h00000100, 32'h00000101, 3'b101, 0);
    txn(0, 32'hFFFFFFFF, 32'h00000001, 3'b100, 0);
    txn(0, 32'h00000100, 32'h00000101, 3'b101, 2);
    txn(1, 32'h80000000, 32'h7FFFFFFF, 3'b101, 5);
    txn(1, 32'h00000005, 32'h00000009, 3'b010, 0);
    txn(0, 32'h00000005, 32'h00000005, 3'b011, 1);
    // flush during the second scan cycle of an equal-operand compare
    sel = 1'b1;
    a = 32'h12345678;
    b = 32'h12345678;
    f3 = 3'b000;
    v1 = 1'b1;
    @(posedge clk);
    #1;
    v1 = 1'b0;
    @(posedge clk);
    #1;
    chk("fl_scan_valid", ovs, 0);
    flush = 1'b1;
    v1 = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    v1 = 1'b0;
    check_quiet("fl");
    watch_no_valid("fl_no_valid");
    flush = 1'b1;
    v1 = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    v1 = 1'b0;
    chk("fl_idle_ready", ord, 1);
    watch_no_valid("fl_idle_no_valid");
    // async reset in the middle of a scan
    txn(1, 32'h12345678, 32'h12345678, 3'b000, 0);
    a = 32'h12345678;
    b = 32'h12345678;
    f3 = 3'b000;
    v1 = 1'b1;
    @(posedge clk);
    #1;
    v1 = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_quiet("arst");
    #3;
    rst_n = 1'b1;
    watch_no_valid("arst_no_valid");
    for (int i = 0; i < 80; i++) begin
      x = $urandom;
      case ($urandom_range(0, 3))
        0: y = $urandom;
        1: y = x;
        2: y = x ^ (32'($urandom_range(1, 255)) << (8 * $urandom_range(0, 3)));
        default: y = {x[31:8], 8'($urandom)};
      endcase
      txn(1'($urandom), x, y, 3'($urandom), $urandom_range(0, 2));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/branch_compare_seq.md
Name: branch_compare_seq

Overview:
Parametrised, multi-cycle magnitude/equality comparator for the RISC-V pipeline's branch and set-less-than path. It scans operands MSB-first in CHUNK-bit slices, one slice per clock, with optional early exit on the first differing slice. It decodes RISC-V branch funct3 to a taken decision and uses valid/ready handshakes on both sides, so it can sit behind the EX-stage operand muxes without a fixed-latency assumption.

Parameters:
WIDTH, 32, operand width in bits; must be a multiple of CHUNK.
CHUNK, 8, bits compared per SCAN cycle; CHUNK==WIDTH gives a one-cycle SCAN.
EARLY_EXIT, 1, 1 = stop at first differing slice; 0 = always scan all NCHUNK=WIDTH/CHUNK slices (constant latency).

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
i_valid  in  1  request valid
o_ready  out  1  request accepted when i_valid&o_ready at rising edge
a  in  WIDTH  operand A
b  in  WIDTH  operand B
i_funct3  in  3  000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU; 010/011 illegal
i_flush  in  1  synchronous kill of any in-flight compare
o_valid  out  1  result valid
i_ready  in  1  result consumed when o_valid&i_ready at rising edge
o_lt  out  1  a<b under signedness of i_funct3
o_eq  out  1  a==b
o_taken  out  1  branch condition true
o_illegal  out  1  captured funct3 was 010 or 011

Behaviour:
- Reset (rst_n low, async): state IDLE; o_ready=1; o_valid=0; o_lt=0; o_eq=0; o_taken=0; o_illegal=0; capture regs 0.
- States: IDLE, SCAN, DONE. o_ready=1 only in IDLE. o_valid=1 only in DONE.
- IDLE: on i_valid & !i_flush, capture a, b, funct3; signed = !funct3[1]. Signed ops: XOR bit WIDTH-1 of both captured operands, so the unsigned scan gives the signed order. Slice index k = NCHUNK-1. Go SCAN.
- SCAN, each cycle: compare slice k of A and B.
  - Slices differ and EARLY_EXIT=1: latch lt = (sliceA < sliceB), eq=0; go DONE.
  - EARLY_EXIT=0: record the first differing slice only; later slices do not overwrite it.
  - k==0: finalise. If no slice differed: eq=1, lt=0. Go DONE.
  - Otherwise k decrements.
- Latency, acceptance edge to o_valid high: m edges. m = 1-based position of the first differing slice from MSB, or NCHUNK if equal. With EARLY_EXIT=0, always NCHUNK. Minimum 1.
- taken, by funct3: BEQ eq; BNE !eq; BLT/BLTU lt; BGE/BGEU !lt.
- Illegal funct3: o_taken=0, o_illegal=1; o_lt/o_eq computed unsigned.
- DONE: o_lt, o_eq, o_taken, o_illegal stable while o_valid & !i_ready. On i_ready, go IDLE; o_valid=0 next cycle. No new request is accepted in the same edge.
- i_flush (any state): next edge goes to IDLE, o_valid=0, result outputs cleared to 0. Flush wins over a simultaneous i_valid, which is not captured, and over a simultaneous i_ready.
- Inputs a/b/i_funct3 are don't-care except on the acceptance edge; changes during SCAN/DONE have no effect.
- Async reset mid-SCAN or mid-DONE returns to reset values immediately; no result is emitted.

Test Plan:
- WIDTH=32, CHUNK=8, EARLY_EXIT=1, BLT a=0xFFFFFFFF b=0x00000001 -> o_valid 1 edge after accept; o_lt=1, o_eq=0, o_taken=1.
- Same operands, BLTU (110) -> latency 1; o_lt=0, o_taken=0. BGEU -> o_taken=1.
- BEQ a=b=0x12345678 -> latency 4; o_eq=1, o_lt=0, o_taken=1. BNE -> o_taken=0.
- BGE a=0x00000100 b=0x00000101 -> latency 4; o_lt=1, o_taken=0. With EARLY_EXIT=0, case 1 also has latency 4 and identical result.
- Backpressure: hold i_ready=0 for 5 cycles in DONE with i_valid=1 and changing a/b -> outputs stable, o_ready=0, nothing captured. i_ready=1 -> o_valid=0 next cycle, o_ready=1.
- i_flush in 2nd SCAN cycle of the BEQ case -> IDLE next edge, o_valid never asserted. Separately, rst_n low mid-SCAN -> immediate reset values. funct3=010 -> o_illegal=1, o_taken=0.
